// File: rtl/fpu_op_scheduler.sv
// Two-requester arbiter/sequencer in front of one shared multi-cycle FPU core.
// Define FPU_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module fpu_op_scheduler #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [WIDTH-1:0]    req0_operand_a,
  input  logic [WIDTH-1:0]    req0_operand_b,
  input  logic [OP_WIDTH-1:0] req0_operation,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [WIDTH-1:0]    req1_operand_a,
  input  logic [WIDTH-1:0]    req1_operand_b,
  input  logic [OP_WIDTH-1:0] req1_operation,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [WIDTH-1:0]    rsp_result,
  output logic                fpu_start,
  output logic [WIDTH-1:0]    fpu_operand_a,
  output logic [WIDTH-1:0]    fpu_operand_b,
  output logic [OP_WIDTH-1:0] fpu_operation,
  input  logic                fpu_done,
  input  logic [WIDTH-1:0]    fpu_result,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [OP_WIDTH-1:0] op;
  } fpu_req_t;

  state_t   state, state_nxt;
  logic     owner;
  logic [1:0] grant;
  logic     accept;
  logic     rsp_hs;
  fpu_req_t req_sel, req_q;

`ifdef FPU_ARB_RR_EN
  logic last_grant;

  // On contention, favour whoever did not win last time.
  always_comb begin
    grant = {req1_valid, req0_valid};
    if (req0_valid && req1_valid)
      grant = last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= grant[1];
  end
`else
  always_comb grant = {req1_valid & ~req0_valid, req0_valid};
`endif

  assign req0_ready = (state == IDLE) & grant[0];
  assign req1_ready = (state == IDLE) & grant[1];
  assign accept     = (state == IDLE) & (|grant);

  assign req_sel = grant[1] ? '{a: req1_operand_a, b: req1_operand_b, op: req1_operation}
                            : '{a: req0_operand_a, b: req0_operand_b, op: req0_operation};

  assign fpu_start     = (state == ISSUE);
  assign busy          = (state != IDLE);
  assign rsp0_valid    = (state == RESP) & ~owner;
  assign rsp1_valid    = (state == RESP) &  owner;
  assign rsp_hs        = owner ? rsp1_ready : rsp0_ready;
  assign fpu_operand_a = req_q.a;
  assign fpu_operand_b = req_q.b;
  assign fpu_operation = req_q.op;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = ISSUE;
      ISSUE:                 state_nxt = WAIT;
      WAIT:    if (fpu_done) state_nxt = RESP;
      RESP:    if (rsp_hs)   state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      req_q      <= '0;
      rsp_result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner <= grant[1];
        req_q <= req_sel;
      end
      // Only a done seen in WAIT belongs to the in-flight op.
      if (state == WAIT && fpu_done)
        rsp_result <= fpu_result;
    end
  end

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Directed bench for fpu_op_scheduler: table of transactions plus hand sequences
// for spurious done, reset mid-operation and request withdrawal.
module tb_fpu_op_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b;
  logic [1:0]  req0_operation, req1_operation;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic        fpu_start, fpu_done, busy;
  logic [31:0] fpu_operand_a, fpu_operand_b, fpu_result;
  logic [1:0]  fpu_operation;

  int n_chk  = 0;
  int n_fail = 0;

  fpu_op_scheduler #(.WIDTH(32), .OP_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b),
    .req0_operation(req0_operation),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b),
    .req1_operation(req1_operation),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result),
    .fpu_start(fpu_start), .fpu_operand_a(fpu_operand_a),
    .fpu_operand_b(fpu_operand_b), .fpu_operation(fpu_operation),
    .fpu_done(fpu_done), .fpu_result(fpu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v0, v1;
    logic [31:0] a0, b0;
    logic [1:0]  op0;
    logic [31:0] a1, b1;
    logic [1:0]  op1;
    int          lat;
    logic [31:0] res;
    int          bp;
    int          exp_owner;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(logic v0, logic v1, int lat, logic [31:0] res, int bp, int own);
    vec_t v;
    v.v0 = v0; v.v1 = v1;
    v.a0 = 32'h3F80_0000; v.b0 = 32'h4000_0000; v.op0 = 2'b00;
    v.a1 = 32'h4080_0000; v.b1 = 32'h40A0_0000; v.op1 = 2'b11;
    v.lat = lat; v.res = res; v.bp = bp; v.exp_owner = own;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    fpu_done = 0;   fpu_result = 32'h0;
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    logic [31:0] ea, eb;
    logic [1:0]  eop;
    ea  = (v.exp_owner == 1) ? v.a1  : v.a0;
    eb  = (v.exp_owner == 1) ? v.b1  : v.b0;
    eop = (v.exp_owner == 1) ? v.op1 : v.op0;
    @(negedge clk);
    req0_valid = v.v0; req0_operand_a = v.a0; req0_operand_b = v.b0; req0_operation = v.op0;
    req1_valid = v.v1; req1_operand_a = v.a1; req1_operand_b = v.b1; req1_operation = v.op1;
    #1;
    chk($sformatf("v%0d req0_ready", idx), 32'(req0_ready), 32'(v.exp_owner == 0));
    chk($sformatf("v%0d req1_ready", idx), 32'(req1_ready), 32'(v.exp_owner == 1));
    chk($sformatf("v%0d busy_idle", idx), 32'(busy), 0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #1;
    chk($sformatf("v%0d fpu_start", idx), 32'(fpu_start), 1);
    chk($sformatf("v%0d operand_a", idx), fpu_operand_a, ea);
    chk($sformatf("v%0d operand_b", idx), fpu_operand_b, eb);
    chk($sformatf("v%0d operation", idx), 32'(fpu_operation), 32'(eop));
    for (int k = 1; k <= v.lat; k++) begin
      @(negedge clk);
      if (k == v.lat) begin fpu_done = 1; fpu_result = v.res; end
      #1;
      chk($sformatf("v%0d start_once", idx), 32'(fpu_start), 0);
      chk($sformatf("v%0d early_rsp", idx), 32'(rsp0_valid | rsp1_valid), 0);
    end
    @(negedge clk);
    fpu_done = 0; fpu_result = ~v.res;
    for (int k = 0; k < v.bp; k++) begin
      req0_valid = 1; req1_valid = 1;
      #1;
      chk($sformatf("v%0d bp_rsp_valid", idx),
          32'(v.exp_owner == 1 ? rsp1_valid : rsp0_valid), 1);
      chk($sformatf("v%0d bp_result", idx), rsp_result, v.res);
      chk($sformatf("v%0d bp_busy", idx), 32'(busy), 1);
      chk($sformatf("v%0d bp_ready", idx), 32'(req0_ready | req1_ready), 0);
      chk($sformatf("v%0d bp_operand_a", idx), fpu_operand_a, ea);
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    if (v.exp_owner == 1) rsp1_ready = 1; else rsp0_ready = 1;
    #1;
    chk($sformatf("v%0d rsp0_valid", idx), 32'(rsp0_valid), 32'(v.exp_owner == 0));
    chk($sformatf("v%0d rsp1_valid", idx), 32'(rsp1_valid), 32'(v.exp_owner == 1));
    chk($sformatf("v%0d rsp_result", idx), rsp_result, v.res);
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;
    #1;
    chk($sformatf("v%0d back_idle", idx), 32'(busy), 0);
  endtask

  // Issue a single-requester op and bring it to WAIT.
  task automatic start_op(input int who, input string nm);
    @(negedge clk);
    if (who == 1) req1_valid = 1; else req0_valid = 1;
    #1;
    chk({nm, " accept"}, 32'(who == 1 ? req1_ready : req0_ready), 1);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #1;
    chk({nm, " start"}, 32'(fpu_start), 1);
  endtask

  task automatic complete(input int own, input logic [31:0] res, input string nm);
    @(negedge clk);
    fpu_done = 1; fpu_result = res;
    #1;
    chk({nm, " no_rsp_yet"}, 32'(rsp0_valid | rsp1_valid), 0);
    @(negedge clk);
    fpu_done = 0; fpu_result = 32'h0;
    if (own == 1) rsp1_ready = 1; else rsp0_ready = 1;
    #1;
    chk({nm, " rsp_valid"}, 32'(own == 1 ? rsp1_valid : rsp0_valid), 1);
    chk({nm, " other_valid"}, 32'(own == 1 ? rsp0_valid : rsp1_valid), 0);
    chk({nm, " result"}, rsp_result, res);
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;
    #1;
    chk({nm, " idle"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
`ifdef FPU_ARB_RR_EN
    vecs[0] = mk(1, 1, 1, 32'h4040_0000, 0, 0);
    vecs[1] = mk(1, 1, 2, 32'h4110_0000, 0, 1);
    vecs[2] = mk(1, 1, 3, 32'h3F00_0000, 0, 0);
    vecs[3] = mk(1, 1, 4, 32'hC080_0000, 0, 1);
`else
    vecs[0] = mk(1, 1, 1, 32'h4040_0000, 0, 0);
    vecs[1] = mk(1, 1, 2, 32'h4110_0000, 0, 0);
    vecs[2] = mk(1, 1, 3, 32'h3F00_0000, 0, 0);
    vecs[3] = mk(1, 1, 4, 32'hC080_0000, 0, 0);
`endif
    vecs[4] = mk(1, 0, 4, 32'h4040_0000, 0, 0);
    vecs[5] = mk(0, 1, 2, 32'h3F4C_CCCD, 5, 1);
    vecs[6] = mk(0, 1, 1, 32'h7F80_0000, 0, 1);
    vecs[7] = mk(1, 1, 2, 32'h4120_0000, 0, 0);

    idle_inputs();
    req0_operand_a = 32'h1111_1111; req0_operand_b = 32'h2222_2222; req0_operation = 2'b01;
    req1_operand_a = 32'h3333_3333; req1_operand_b = 32'h4444_4444; req1_operation = 2'b10;
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy", 32'(busy), 0);
    chk("reset start", 32'(fpu_start), 0);
    chk("reset rsp_valid", 32'(rsp0_valid | rsp1_valid), 0);
    chk("reset operand_a", fpu_operand_a, 0);
    chk("reset rsp_result", rsp_result, 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // Spurious done in IDLE, then in ISSUE.
    @(negedge clk);
    fpu_done = 1; fpu_result = 32'hDEAD_BEEF;
    @(negedge clk);
    fpu_done = 0;
    #1;
    chk("spur_idle busy", 32'(busy), 0);
    chk("spur_idle rsp", 32'(rsp0_valid | rsp1_valid), 0);
    @(negedge clk);
    req0_valid = 1;
    #1;
    chk("spur_issue accept", 32'(req0_ready), 1);
    @(negedge clk);
    req0_valid = 0; fpu_done = 1; fpu_result = 32'hDEAD_BEEF;
    #1;
    chk("spur_issue start", 32'(fpu_start), 1);
    @(negedge clk);
    fpu_done = 0;
    #1;
    chk("spur_issue busy", 32'(busy), 1);
    chk("spur_issue rsp", 32'(rsp0_valid | rsp1_valid), 0);
    @(negedge clk);
    #1;
    chk("spur_issue still_wait", 32'(rsp0_valid | rsp1_valid), 0);
    complete(0, 32'h4200_0000, "spur_issue");

    // Reset while waiting on the core.
    start_op(1, "rst_wait");
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_wait busy", 32'(busy), 0);
    chk("rst_wait start", 32'(fpu_start), 0);
    chk("rst_wait rsp_valid", 32'(rsp0_valid | rsp1_valid), 0);
    chk("rst_wait ready", 32'(req0_ready | req1_ready), 0);
    chk("rst_wait operand_a", fpu_operand_a, 0);
    chk("rst_wait operation", 32'(fpu_operation), 0);
    chk("rst_wait rsp_result", rsp_result, 0);
    @(negedge clk);
    fpu_done = 1; fpu_result = 32'hCAFE_F00D;
    @(negedge clk);
    fpu_done = 0;
    #1;
    chk("late_done busy", 32'(busy), 0);
    chk("late_done rsp", 32'(rsp0_valid | rsp1_valid), 0);
    chk("late_done result", rsp_result, 0);
    run_txn(vecs[7], 7);

    // req1 shows up during a req0 op, then withdraws before IDLE.
    start_op(0, "withdraw");
    @(negedge clk);
    req1_valid = 1;
    #1;
    chk("withdraw ready1_a", 32'(req1_ready), 0);
    @(negedge clk);
    #1;
    chk("withdraw ready1_b", 32'(req1_ready), 0);
    req1_valid = 0;
    complete(0, 32'h3E80_0000, "withdraw");
    @(negedge clk);
    #1;
    chk("withdraw no_accept", 32'(busy), 0);
    chk("withdraw no_start", 32'(fpu_start), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
